// File: rtl/avalon_ram_pkg.sv
// ---------------------------------------------------------------------------
// avalon_ram_pkg
// Shared types and constants for the Avalon-MM on-chip RAM slave.
//   state_e : controller states (zero-fill, one-cycle arm, normal operation)
//   RL_MAX  : deepest supported read pipeline
//   lanes() : number of byte lanes for a given data width
// ---------------------------------------------------------------------------
package avalon_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE_ARM = 2'd1,
    READY    = 2'd2
  } state_e;

  localparam int RL_MAX = 2;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bytelane_ram.sv
// ---------------------------------------------------------------------------
// bytelane_ram
// Inferable single-port RAM, DATA_W wide and 2^ADDR_W deep, with one write
// enable per byte lane and a registered read port. Everything is gated by a
// common clock enable.
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset (read register only)
//   ce_i    : clock enable; low freezes array and read register
//   we_i    : per-lane write enables
//   re_i    : read enable; loads rdata_o from mem[addr_i]
//   addr_i  : word address shared by read and write
//   wdata_i : write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module bytelane_ram
  import avalon_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ce_i,
  input  logic [lanes(DATA_W)-1:0]  we_i,
  input  logic                      re_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int LANES = lanes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset branch; a reset on a memory prevents RAM
  // inference. Zeroing, when wanted, is done by the controller's fill pass.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (ce_i && re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_onchip_ram_ctl.sv
// ---------------------------------------------------------------------------
// avalon_onchip_ram_ctl
// Single-port Avalon-MM on-chip RAM slave: optional zero-fill after reset,
// waitrequest back-pressure, clock-enable stall, READ_LATENCY-deep
// readdatavalid pipeline.
//   clk_i           : rising-edge clock
//   reset_i         : synchronous active-high reset
//   address_i       : word address
//   byteenable_i    : write lane enables (ignored on reads)
//   chipselect_i    : slave select
//   read_i/write_i  : transfer requests (write wins when both are high)
//   writedata_i     : write data
//   clken_i         : clock enable; low stalls memory, pipeline and fill
//   readdata_o      : read data, meaningful only with readdatavalid_o
//   readdatavalid_o : one-cycle pulse per accepted read
//   waitrequest_o   : request not accepted this cycle
//   init_done_o     : fill complete; stays high until the next reset
// ---------------------------------------------------------------------------
module avalon_onchip_ram_ctl
  import avalon_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_W-1:0]     address_i,
  input  logic [DATA_W/8-1:0]   byteenable_i,
  input  logic                  chipselect_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [DATA_W-1:0]     writedata_i,
  input  logic                  clken_i,
  output logic [DATA_W-1:0]     readdata_o,
  output logic                  readdatavalid_o,
  output logic                  waitrequest_o,
  output logic                  init_done_o
);

  localparam int LANES = lanes(DATA_W);
  // Out-of-range latencies are clamped to the supported 1..RL_MAX.
  localparam int RL = (READ_LATENCY > RL_MAX) ? RL_MAX :
                      (READ_LATENCY < 1)      ? 1      : READ_LATENCY;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE_ARM;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic [RL-1:0]     vld_q, vld_d;

  logic              ready;
  logic              accept;
  logic              wr_accept;
  logic              rd_launch;

  logic [LANES-1:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // -------------------------------------------------------------------------
  // Request arbitration
  // -------------------------------------------------------------------------
  assign ready         = (state_q == READY);
  assign waitrequest_o = ~ready | ~clken_i;
  assign init_done_o   = ready;

  assign accept    = chipselect_i & (read_i | write_i) & ~waitrequest_o;
  assign wr_accept = accept & write_i;
  // A combined read+write performs only the write.
  assign rd_launch = accept & read_i & ~write_i;

  // -------------------------------------------------------------------------
  // FSM next state and RAM port steering
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ram_we      = '0;
    ram_addr    = address_i;
    ram_wdata   = writedata_i;

    if (clken_i) begin
      unique case (state_q)
        CLEAR: begin
          ram_we      = '1;
          ram_addr    = clear_ptr_q;
          ram_wdata   = '0;
          clear_ptr_d = clear_ptr_q + 1'b1;
          if (&clear_ptr_q) begin
            state_d = READY;
          end
        end
        IDLE_ARM: begin
          state_d = READY;
        end
        READY: begin
          if (wr_accept) begin
            ram_we = byteenable_i;
          end
        end
        default: begin
          state_d = RESET_STATE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read-valid pipeline and output data stage
  // -------------------------------------------------------------------------
  if (RL == 1) begin : g_rl1
    assign vld_d      = clken_i ? rd_launch : vld_q;
    assign readdata_o = ram_rdata;
  end else begin : g_rl2
    logic [DATA_W-1:0] rdata2_q;

    assign vld_d = clken_i ? {vld_q[0], rd_launch} : vld_q;

    // Loads only when a real read leaves the RAM stage, so readdata holds
    // its last delivered value between pulses.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rdata2_q <= '0;
      end else if (clken_i && vld_q[0]) begin
        rdata2_q <= ram_rdata;
      end
    end

    assign readdata_o = rdata2_q;
  end

  // A stalled pulse is held in the pipeline but hidden until clken returns.
  assign readdatavalid_o = vld_q[RL-1] & clken_i;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RESET_STATE;
      clear_ptr_q <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      vld_q       <= vld_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  bytelane_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ce_i    (clken_i),
    .we_i    (ram_we),
    .re_i    (rd_launch),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_avalon_onchip_ram_ctl.sv
// ---------------------------------------------------------------------------
// tb_avalon_onchip_ram_ctl
// Two instances share one stimulus stream:
//   inst 0 : ADDR_W=4, READ_LATENCY=2, CLEAR_ON_RESET=1
//   inst 1 : ADDR_W=4, READ_LATENCY=1, CLEAR_ON_RESET=0
// A transaction-level model (word array, ready countdown, queue of pending
// reads) predicts outputs every cycle; directed steps add literal checks.
// Inputs change 2ns after posedge; outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_avalon_onchip_ram_ctl;

  logic        clk;
  logic        reset;
  logic [3:0]  addr;
  logic [3:0]  byteen;
  logic        cs, rd, wr;
  logic [31:0] wdata;
  logic        clken;

  logic [31:0] dut_rdata [2];
  logic [1:0]  dut_vld, dut_wait, dut_done;

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  avalon_onchip_ram_ctl #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut0 (
    .clk_i(clk), .reset_i(reset), .address_i(addr), .byteenable_i(byteen),
    .chipselect_i(cs), .read_i(rd), .write_i(wr), .writedata_i(wdata),
    .clken_i(clken), .readdata_o(dut_rdata[0]), .readdatavalid_o(dut_vld[0]),
    .waitrequest_o(dut_wait[0]), .init_done_o(dut_done[0])
  );

  avalon_onchip_ram_ctl #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) u_dut1 (
    .clk_i(clk), .reset_i(reset), .address_i(addr), .byteenable_i(byteen),
    .chipselect_i(cs), .read_i(rd), .write_i(wr), .writedata_i(wdata),
    .clken_i(clken), .readdata_o(dut_rdata[1]), .readdatavalid_o(dut_vld[1]),
    .waitrequest_o(dut_wait[1]), .init_done_o(dut_done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  logic [31:0] mmem   [2][16];
  bit          mknown [2][16];
  int          init_left [2];
  int          pn [2];
  int          pc [2][4];
  logic [31:0] pd [2][4];
  bit          pk [2][4];
  bit          started = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        started      = 1'b1;
        pn[k]        = 0;
        init_left[k] = (k == 0) ? 16 : 1;
        if (k == 0) begin
          for (int a = 0; a < 16; a++) begin
            mmem[k][a]   = 32'h0;
            mknown[k][a] = 1'b1;
          end
        end
      end else if (clken && started) begin
        bit rdy;
        bit acc;
        rdy = (init_left[k] == 0);
        acc = rdy && cs && (rd || wr);
        // retire the read presented during the cycle that just ended
        if (pn[k] > 0 && pc[k][0] == 0) begin
          for (int j = 1; j < 4; j++) begin
            pc[k][j-1] = pc[k][j];
            pd[k][j-1] = pd[k][j];
            pk[k][j-1] = pk[k][j];
          end
          pn[k]--;
        end
        for (int j = 0; j < pn[k]; j++) pc[k][j]--;
        if (acc && wr) begin
          for (int b = 0; b < 4; b++)
            if (byteen[b]) mmem[k][addr][8*b +: 8] = wdata[8*b +: 8];
          if (byteen == 4'hF) mknown[k][addr] = 1'b1;
        end else if (acc && rd) begin
          pc[k][pn[k]] = lat_of(k) - 1;
          pd[k][pn[k]] = mmem[k][addr];
          pk[k][pn[k]] = mknown[k][addr];
          pn[k]++;
        end
        if (!rdy) init_left[k]--;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare and read capture
  // -------------------------------------------------------------------------
  logic [31:0] cap_d [2][$];
  int          cap_c [2][$];
  int          pcnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit e_wait, e_vld;
        e_wait = (init_left[k] != 0) || !clken;
        e_vld  = clken && (pn[k] > 0) && (pc[k][0] == 0);
        check($sformatf("waitrequest[%0d]", k), 32'(dut_wait[k]), 32'(e_wait));
        check($sformatf("init_done[%0d]", k), 32'(dut_done[k]), 32'(init_left[k] == 0));
        check($sformatf("readdatavalid[%0d]", k), 32'(dut_vld[k]), 32'(e_vld));
        if (e_vld && pk[k][0])
          check($sformatf("readdata[%0d]", k), dut_rdata[k], pd[k][0]);
        if (dut_vld[k]) begin
          cap_d[k].push_back(dut_rdata[k]);
          cap_c[k].push_back(cyc);
          pcnt[k]++;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic drive(input bit c, input bit r, input bit w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #2;
    cs = c; rd = r; wr = w; addr = a; wdata = d; byteen = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
  endtask

  // Counts negedges with inst 0 waitrequest high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!dut_wait[0]) break;
      n++;
    end
  endtask

  task automatic expect_read(input string name, input int k, input logic [31:0] exp,
                             output int c);
    bit ok = 1'b0;
    c = -1;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (cap_d[k].size() > 0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no readdatavalid pulse on inst %0d, expected data %h", name, k, exp);
    end else begin
      c = cap_c[k].pop_front();
      check(name, cap_d[k].pop_front(), exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int n, c0, c1, acc, p0, p1;
    reset = 1'b1; clken = 1'b1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; byteen = '0;

    // Reset values
    @(posedge clk); @(negedge clk);
    check("reset_rdata0", dut_rdata[0], 32'h0);
    check("reset_rdata1", dut_rdata[1], 32'h0);
    check("reset_wait", 32'(dut_wait), 32'h3);
    check("reset_done", 32'(dut_done), 32'h0);
    @(posedge clk); #2; reset = 1'b0;
    wait_ready(n);
    check("initial_clear_cycles", 32'(n), 32'd16);

    // Zero-fill: preload, reset, 16-cycle clear, read back
    drive(1, 0, 1, 4'd3, 32'hDEADBEEF, 4'hF);
    idle();
    pulse_reset();
    wait_ready(n);
    check("refill_cycles", 32'(n), 32'd16);
    drive(1, 1, 0, 4'd3, 32'h0, 4'h0);
    idle();
    expect_read("zero_fill_addr3", 0, 32'h0, c0);
    expect_read("retain_addr3", 1, 32'hDEADBEEF, c1);

    // Byte merge: lanes 0 and 2 replaced
    drive(1, 0, 1, 4'd5, 32'h11223344, 4'hF);
    drive(1, 0, 1, 4'd5, 32'hAABBCCDD, 4'h5);
    drive(1, 1, 0, 4'd5, 32'h0, 4'h0);
    idle();
    expect_read("merge0", 0, 32'h11BB33DD, c0);
    expect_read("merge1", 1, 32'h11BB33DD, c1);

    // Latency: back-to-back reads 0,1,2. A pulse visible in the cycle after
    // edge acc+L-1 is sampled by the master at edge acc+L.
    for (int a = 0; a < 3; a++) drive(1, 0, 1, 4'(a), 32'hC0DE0000 + 32'(a), 4'hF);
    drive(1, 1, 0, 4'd0, 32'h0, 4'h0);
    acc = cyc + 1;
    drive(1, 1, 0, 4'd1, 32'h0, 4'h0);
    drive(1, 1, 0, 4'd2, 32'h0, 4'h0);
    idle();
    for (int a = 0; a < 3; a++) begin
      expect_read($sformatf("lat2_data%0d", a), 0, 32'hC0DE0000 + 32'(a), c0);
      check($sformatf("lat2_cycle%0d", a), 32'(c0), 32'(acc + 1 + a));
      expect_read($sformatf("lat1_data%0d", a), 1, 32'hC0DE0000 + 32'(a), c1);
      check($sformatf("lat1_cycle%0d", a), 32'(c1), 32'(acc + a));
    end

    // clken stall: 3 disabled edges after the accept
    drive(1, 1, 0, 4'd1, 32'h0, 4'h0);
    acc = cyc + 1;
    @(posedge clk); #2;
    cs = 1'b0; rd = 1'b0; clken = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_wait", 32'(dut_wait), 32'h3);
      check("stall_novalid", 32'(dut_vld), 32'h0);
    end
    @(posedge clk); #2; clken = 1'b1;
    expect_read("stall_data1", 1, 32'hC0DE0001, c1);
    check("stall_cycle1", 32'(c1), 32'(acc + 3));
    expect_read("stall_data0", 0, 32'hC0DE0001, c0);
    check("stall_cycle0", 32'(c0), 32'(acc + 4));

    // Simultaneous read and write: write only
    p0 = pcnt[0]; p1 = pcnt[1];
    drive(1, 1, 1, 4'd7, 32'h5A5A5A5A, 4'hF);
    idle();
    repeat (5) @(negedge clk);
    check("rw_nopulse0", 32'(pcnt[0] - p0), 32'h0);
    check("rw_nopulse1", 32'(pcnt[1] - p1), 32'h0);
    drive(1, 1, 0, 4'd7, 32'h0, 4'h0);
    idle();
    expect_read("rw_data0", 0, 32'h5A5A5A5A, c0);
    expect_read("rw_data1", 1, 32'h5A5A5A5A, c1);

    // Reset with a read in flight, then again midway through the clear
    p0 = pcnt[0];
    drive(1, 1, 0, 4'd7, 32'h0, 4'h0);
    @(posedge clk); #2;
    cs = 1'b0; rd = 1'b0; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    repeat (8) @(posedge clk);
    #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    wait_ready(n);
    check("restart_clear_cycles", 32'(n), 32'd16);
    check("dropped_pulse0", 32'(pcnt[0] - p0), 32'h0);
    expect_read("inflight_rl1", 1, 32'h5A5A5A5A, c1);
    drive(1, 1, 0, 4'd7, 32'h0, 4'h0);
    idle();
    expect_read("recleared0", 0, 32'h0, c0);
    expect_read("retained1", 1, 32'h5A5A5A5A, c1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
             vectors, miscompares);
    $fatal(1);
  end

endmodule
